// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors match datapath.
package rps_pkg;

    // Match controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Winner encoding
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;

    // Round wins needed to take the match (best-of-5)
    localparam int DEFAULT_WIN_TARGET = 3;

    // One-hot move codes used by the upstream move-compare stage
    localparam logic [2:0] MOVE_ROCK     = 3'b001;
    localparam logic [2:0] MOVE_PAPER    = 3'b010;
    localparam logic [2:0] MOVE_SCISSORS = 3'b100;

endpackage

// File: rtl/sat_counter.sv
// 4-bit up counter with synchronous clear, increment enable and a
// parameterised saturation ceiling.
module sat_counter #(
    parameter logic [3:0] MAX = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] count
);

    logic [3:0] count_reg;

    // Clear has priority over increment; increments stop at MAX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 4'd0;
        end else if (clr) begin
            count_reg <= 4'd0;
        end else if (inc && (count_reg != MAX)) begin
            count_reg <= count_reg + 4'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/match_scoreboard.sv
// Match scoreboard: tracks round wins for two players and tied rounds,
// declares the match winner once a player reaches WIN_TARGET wins.
module match_scoreboard
    import rps_pkg::*;
#(
    parameter int WIN_TARGET = DEFAULT_WIN_TARGET
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rnd_valid,
    input  logic       Tie,
    input  logic       WinA,
    input  logic       MoveErr,
    output logic [3:0] scoreA,
    output logic [3:0] scoreB,
    output logic [3:0] ties,
    output logic       bad_round,
    output logic       busy,
    output logic       match_done,
    output logic [1:0] winner
);

    localparam logic [3:0] WIN_T4   = 4'(WIN_TARGET);
    localparam logic [3:0] WIN_LAST = WIN_T4 - 4'd1;
    localparam logic [3:0] TIE_MAX  = 4'd15;

    // Counter slot assignment: 0 = player A, 1 = player B, 2 = ties
    localparam int SLOT_A   = 0;
    localparam int SLOT_B   = 1;
    localparam int SLOT_TIE = 2;

    state_t     state_reg;
    state_t     state_next;

    logic       busy_reg;
    logic       busy_next;
    logic       done_reg;
    logic       done_next;
    logic       bad_reg;
    logic       bad_next;
    logic [1:0] winner_reg;
    logic [1:0] winner_next;

    logic       round_ok;
    logic       inc_a;
    logic       inc_b;
    logic       inc_tie;
    logic       win_a;
    logic       win_b;
    logic [2:0] inc_vec;
    logic [3:0] count_arr [3];

    // Round decode: a round counts only while playing and not overridden by start
    always_comb begin
        round_ok = (state_reg == PLAY) && rnd_valid && !start;
        inc_tie  = round_ok && !MoveErr && Tie;
        inc_a    = round_ok && !MoveErr && !Tie && WinA;
        inc_b    = round_ok && !MoveErr && !Tie && !WinA;
        win_a    = inc_a && (count_arr[SLOT_A] == WIN_LAST);
        win_b    = inc_b && (count_arr[SLOT_B] == WIN_LAST);
        inc_vec  = {inc_tie, inc_b, inc_a};
    end

    // Score and tie counters share one clear (start) and saturate at their ceilings
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            localparam logic [3:0] CNT_MAX = (gi == SLOT_TIE) ? TIE_MAX : WIN_T4;
            sat_counter #(
                .MAX (CNT_MAX)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .clr   (start),
                .inc   (inc_vec[gi]),
                .count (count_arr[gi])
            );
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; start restarts from any state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = PLAY;
            end
            PLAY: begin
                if (start)              state_next = PLAY;
                else if (win_a || win_b) state_next = DONE;
            end
            DONE: begin
                if (start) state_next = PLAY;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered status outputs
    always_comb begin
        busy_next   = (state_next == PLAY);
        done_next   = (state_next == DONE);
        bad_next    = round_ok && MoveErr;
        winner_next = winner_reg;
        if (start) begin
            winner_next = WIN_NONE;
        end else if (win_a) begin
            winner_next = WIN_A;
        end else if (win_b) begin
            winner_next = WIN_B;
        end
    end

    // Status output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            bad_reg    <= 1'b0;
            winner_reg <= WIN_NONE;
        end else begin
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            bad_reg    <= bad_next;
            winner_reg <= winner_next;
        end
    end

    assign scoreA     = count_arr[SLOT_A];
    assign scoreB     = count_arr[SLOT_B];
    assign ties       = count_arr[SLOT_TIE];
    assign bad_round  = bad_reg;
    assign busy       = busy_reg;
    assign match_done = done_reg;
    assign winner     = winner_reg;

endmodule

// File: tb/tb_match_scoreboard.sv
// Self-checking bench for match_scoreboard: directed scenarios followed by
// random move pairs, compared against a behavioural match model.
module tb_match_scoreboard;
    import rps_pkg::*;

    localparam int W = DEFAULT_WIN_TARGET;

    logic       clk;
    logic       rst;
    logic       start;
    logic       rnd_valid;
    logic       Tie;
    logic       WinA;
    logic       MoveErr;
    logic [3:0] scoreA;
    logic [3:0] scoreB;
    logic [3:0] ties;
    logic       bad_round;
    logic       busy;
    logic       match_done;
    logic [1:0] winner;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the match
    int m_a, m_b, m_t, m_win;
    bit m_play, m_done, m_bad;

    match_scoreboard #(.WIN_TARGET(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rnd_valid  (rnd_valid),
        .Tie        (Tie),
        .WinA       (WinA),
        .MoveErr    (MoveErr),
        .scoreA     (scoreA),
        .scoreB     (scoreB),
        .ties       (ties),
        .bad_round  (bad_round),
        .busy       (busy),
        .match_done (match_done),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".scoreA"}, int'(scoreA), m_a);
        check({tag, ".scoreB"}, int'(scoreB), m_b);
        check({tag, ".ties"}, int'(ties), m_t);
        check({tag, ".bad_round"}, int'(bad_round), int'(m_bad));
        check({tag, ".busy"}, int'(busy), int'(m_play));
        check({tag, ".match_done"}, int'(match_done), int'(m_done));
        check({tag, ".winner"}, int'(winner), m_win);
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_t = 0; m_win = 0;
        m_play = 0; m_done = 0; m_bad = 0;
    endtask

    // Advance the model by one clock given this cycle's inputs
    task automatic model_step(input bit st, input bit rv, input bit t, input bit wa, input bit e);
        m_bad = 0;
        if (st) begin
            m_a = 0; m_b = 0; m_t = 0; m_win = 0;
            m_play = 1; m_done = 0;
        end else if (m_play && rv) begin
            if (e) begin
                m_bad = 1;
            end else if (t) begin
                if (m_t < 15) m_t++;
            end else if (wa) begin
                m_a++;
                if (m_a == W) begin m_play = 0; m_done = 1; m_win = 1; end
            end else begin
                m_b++;
                if (m_b == W) begin m_play = 0; m_done = 1; m_win = 2; end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model
    task automatic step(input string tag, input bit st, input bit rv, input bit t,
                        input bit wa, input bit e);
        start = st; rnd_valid = rv; Tie = t; WinA = wa; MoveErr = e;
        model_step(st, rv, t, wa, e);
        @(posedge clk);
        #1;
        check_all(tag);
        start = 0; rnd_valid = 0;
    endtask

    function automatic bit onehot3(input logic [2:0] m);
        return (m == MOVE_ROCK) || (m == MOVE_PAPER) || (m == MOVE_SCISSORS);
    endfunction

    function automatic bit beats(input logic [2:0] x, input logic [2:0] y);
        return (x == MOVE_ROCK && y == MOVE_SCISSORS) ||
               (x == MOVE_PAPER && y == MOVE_ROCK) ||
               (x == MOVE_SCISSORS && y == MOVE_PAPER);
    endfunction

    initial begin
        logic [2:0] mv_a, mv_b;
        bit st, rv;

        rst = 1; start = 0; rnd_valid = 0; Tie = 0; WinA = 0; MoveErr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 0;

        // Idle edge after release: nothing changes, IDLE ignores rounds
        step("idle_quiet", 0, 0, 0, 0, 0);
        step("idle_round", 0, 1, 0, 1, 0);
        step("idle_err", 0, 1, 0, 0, 1);

        // Three straight wins for A
        step("a3.start", 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("a3.round", 0, 1, 0, 1, 0);

        // A,B,A,B,B then a round in DONE
        step("ab.start", 1, 0, 0, 0, 0);
        step("ab.r1", 0, 1, 0, 1, 0);
        step("ab.r2", 0, 1, 0, 0, 0);
        step("ab.r3", 0, 1, 0, 1, 0);
        step("ab.r4", 0, 1, 0, 0, 0);
        step("ab.r5", 0, 1, 0, 0, 0);
        step("ab.done_round", 0, 1, 0, 1, 0);
        step("ab.done_hold", 0, 0, 0, 0, 0);

        // 17 ties saturate at 15; Tie with WinA still counts as a tie
        step("tie.start", 1, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) step("tie.round", 0, 1, 1, (i % 2) == 1, 0);

        // Rejected round: bad_round pulses once, counters hold
        step("err.start", 1, 0, 0, 0, 0);
        step("err.win", 0, 1, 0, 1, 0);
        step("err.round", 0, 1, 1, 0, 1);
        step("err.after", 0, 0, 0, 0, 0);

        // Start collides with a winning-looking round at scoreA=2
        step("col.a1", 0, 1, 0, 1, 0);
        step("col.hit", 1, 1, 0, 1, 0);
        step("col.after", 0, 1, 0, 1, 0);

        // Asynchronous reset mid-cycle with scoreA=2
        step("ar.a", 0, 1, 0, 1, 0);
        #1 rst = 1;
        #1;
        model_reset();
        check_all("async_rst");
        #1 rst = 0;
        step("ar.idle_round", 0, 1, 0, 1, 0);

        // Random matches from move pairs, with occasional resets
        for (int n = 0; n < 400; n++) begin
            st = ($urandom_range(0, 11) == 0);
            rv = $urandom_range(0, 1);
            mv_a = 3'b001 << $urandom_range(0, 2);
            mv_b = 3'b001 << $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) mv_a = 3'($urandom);
            if ($urandom_range(0, 7) == 0) mv_b = 3'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk);
                rst = 1;
                #1;
                model_reset();
                check_all("rnd.rst");
                rst = 0;
            end
            step("rnd", st, rv, mv_a == mv_b, beats(mv_a, mv_b),
                 !(onehot3(mv_a) && onehot3(mv_b)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/match_scoreboard.md
MATCH_SCOREBOARD -- requirements
Module: match_scoreboard

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below, clock and reset first.
REQ-002 Parameter WIN_TARGET, default 3, SHALL set the round wins needed to take the match (best-of-5 at the default); legal range 1..15.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  single-cycle pulse; clears all scores and begins a match.
REQ-006 rnd_valid  input  1  single-cycle pulse; a round result is present on Tie/WinA/MoveErr this cycle.
REQ-007 Tie  input  1  from the tie-detect stage; both moves identical.
REQ-008 WinA  input  1  player A beats player B; meaningful only when Tie=0 and MoveErr=0.
REQ-009 MoveErr  input  1  either move is not one-hot.
REQ-010 scoreA  output  4  player A round wins.
REQ-011 scoreB  output  4  player B round wins.
REQ-012 ties  output  4  tied rounds, saturating.
REQ-013 bad_round  output  1  one-cycle pulse; a round was rejected.
REQ-014 busy  output  1  high while a match is in progress.
REQ-015 match_done  output  1  level; high from match end until the next start.
REQ-016 winner  output  2  match winner: 00 none, 01 A, 10 B.

Function
REQ-017 The FSM SHALL have three states: IDLE, PLAY and DONE.
REQ-018 IDLE->PLAY on start; PLAY->DONE when either score reaches WIN_TARGET; DONE->PLAY on start; PLAY->PLAY on start (restart).
REQ-019 Every start SHALL zero scoreA, scoreB and ties and set winner=00 on the next edge, in any state.
REQ-020 In PLAY with rnd_valid=1 the block SHALL act on exactly one case, in this priority:
- MoveErr=1: bad_round pulses the next cycle; no counter changes.
- Tie=1: ties += 1.
- WinA=1: scoreA += 1.
- Otherwise: scoreB += 1.
REQ-021 Counters SHALL update one cycle after the rnd_valid edge (registered, latency 1).
REQ-022 ties SHALL saturate at 15; scoreA and scoreB never exceed WIN_TARGET.
REQ-023 When a score increment reaches WIN_TARGET, the same edge SHALL set the DONE state, match_done=1, busy=0 and winner to that player.
REQ-024 rnd_valid in IDLE or DONE SHALL be ignored: no counter change and no bad_round pulse.
REQ-025 start and rnd_valid asserted in the same cycle: start SHALL win and the round SHALL be discarded.
REQ-026 busy SHALL equal (state==PLAY); match_done SHALL equal (state==DONE); both are registered.
REQ-027 Tie=1 together with WinA=1 is treated as a tie (REQ-020 priority).

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE; scoreA, scoreB, ties = 0; winner = 00; busy, match_done, bad_round = 0.
REQ-029 rst asserted mid-match SHALL abandon the match; after release the block waits in IDLE for start.
REQ-030 No output SHALL change on the first edge after release unless start or rnd_valid is sampled.

Structure
REQ-031 A shared package rps_pkg SHALL hold:
- the FSM state enum (IDLE/PLAY/DONE);
- the winner encoding constants (NONE/A/B);
- the default WIN_TARGET;
- the one-hot move constants (ROCK/PAPER/SCISSORS).
REQ-032 One sub-module, sat_counter (4-bit, synchronous clear, increment enable, saturation at a parameterised maximum), SHALL be instantiated three times.

Verification
REQ-033 Reset, start, then 3 rounds of WinA=1 -> scoreA=1,2,3; on the third edge match_done=1, winner=01, busy=0.
REQ-034 A,B,A,B,B rounds -> final scoreA=2, scoreB=3, winner=10; a further rnd_valid in DONE changes nothing.
REQ-035 17 rounds with Tie=1 -> ties holds at 15; scores stay 0; busy stays 1.
REQ-036 rnd_valid with MoveErr=1 and Tie=1 -> bad_round pulses once; all counters unchanged.
REQ-037 start and rnd_valid with WinA=1 in the same cycle, with scoreA=2 -> all counters become 0; state is PLAY.
REQ-038 rst pulsed asynchronously mid-cycle with scoreA=2 -> outputs are zero before the next clock edge; IDLE ignores rnd_valid.
